div_operand_gen: RTL and testbench

Synthesizable operand sequencer that drives the z/d inputs of the unsigned divider pipeline. It sweeps a nested operand space: d is the inner loop and z is the outer loop. It also forwards each issued operand pair, plus precomputed div0/ovf expectations, through a delay line matched to the divider latency. The downstream result checker therefore sees the operands aligned with the q/s they produced. It sits between the bench/control logic and the divider, and replaces hard-coded stimulus loops.

---
 rtl/div_tb_pkg.sv | 15 +
 rtl/div_operand_gen_if.sv | 30 +++
 rtl/div_delay_line.sv | 24 ++
 rtl/div_operand_gen.sv | 110 +++++++++++
 tb/tb_div_operand_gen.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/div_tb_pkg.sv
// Shared definitions for the divider operand sequencer and its result checker.
// The overflow rule lives here so that the generator and the checker use the same definition.
package div_tb_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} gen_state_t;

  localparam int Z_WIDTH_DFLT = 16;
  localparam int D_WIDTH_DFLT = Z_WIDTH_DFLT / 2;

  // Quotient overflow: the upper half of the dividend already reaches the divisor
  function automatic logic ovf_pred(input logic [31:0] z_hi, input logic [31:0] d);
    return (d != 32'd0) && (z_hi >= d);
  endfunction

endpackage

// File: rtl/div_operand_gen_if.sv
// Operand/result bundle between the sequencer (master) and the bench/checker side (slave).
interface div_operand_gen_if
  import div_tb_pkg::*;
#(
  parameter int z_width = Z_WIDTH_DFLT,
  parameter int d_width = z_width / 2
);
  logic               start;
  logic [z_width-1:0] z;
  logic [d_width-1:0] d;
  logic               issue_vld;
  logic               busy;
  logic               done;
  logic               res_vld;
  logic [z_width-1:0] res_z;
  logic [d_width-1:0] res_d;
  logic               exp_div0;
  logic               exp_ovf;
  logic [15:0]        vec_cnt;

  modport master (
    input  start,
    output z, d, issue_vld, busy, done, res_vld, res_z, res_d, exp_div0, exp_ovf, vec_cnt
  );

  modport slave (
    output start,
    input  z, d, issue_vld, busy, done, res_vld, res_z, res_d, exp_div0, exp_ovf, vec_cnt
  );
endinterface

// File: rtl/div_delay_line.sv
// Enabled shift register with async clear; an entry pushed in enabled cycle n leaves in cycle n+depth.
module div_delay_line #(
  parameter int depth = 12,
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [width-1:0] din,
  output logic [width-1:0] dout
);
  logic [width-1:0] stage [depth];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < depth; i++) stage[i] <= '0;
    end else if (ena) begin
      stage[0] <= din;
      for (int i = 1; i < depth; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[depth-1];
endmodule

// File: rtl/div_operand_gen.sv
// Nested z/d operand sweep for the divider, with expectations delayed to line up with q/s.
module div_operand_gen
  import div_tb_pkg::*;
#(
  parameter int z_width  = Z_WIDTH_DFLT,
  parameter int d_width  = z_width / 2,
  parameter int pipeline = d_width + 4,
  parameter int Z_START  = 50,
  parameter int Z_STEP   = 123,
  parameter int Z_LIMIT  = 5000,
  parameter int D_START  = 10,
  parameter int D_LIMIT  = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  div_operand_gen_if.master bus
);
  localparam int CW = $clog2(pipeline + 1);
  localparam int LW = z_width + d_width + 3;
  localparam bit EMPTY = (Z_START >= Z_LIMIT) || (D_START >= D_LIMIT);

  gen_state_t         state, state_nxt;
  logic [z_width-1:0] z_r, z_nxt;
  logic [d_width-1:0] d_r, d_nxt;
  logic [15:0]        cnt_r, cnt_nxt;
  logic [CW-1:0]      drain_r, drain_nxt;
  logic [z_width:0]   z_sum;
  logic [d_width:0]   d_inc;
  logic               issue, div0, ovf;
  logic [LW-1:0]      line_in, line_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      z_r     <= '0;
      d_r     <= '0;
      cnt_r   <= '0;
      drain_r <= '0;
    end else if (ena) begin
      state   <= state_nxt;
      z_r     <= z_nxt;
      d_r     <= d_nxt;
      cnt_r   <= cnt_nxt;
      drain_r <= drain_nxt;
    end
  end

  // The sum carries one extra bit so a wrap past the top of z ends the sweep instead of restarting it
  always_comb begin
    state_nxt = state;
    z_nxt     = z_r;
    d_nxt     = d_r;
    cnt_nxt   = cnt_r;
    drain_nxt = drain_r;
    z_sum     = {1'b0, z_r} + (z_width+1)'(Z_STEP);
    d_inc     = {1'b0, d_r} + 1'b1;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          z_nxt     = z_width'(Z_START);
          d_nxt     = d_width'(D_START);
          cnt_nxt   = '0;
          drain_nxt = '0;
          state_nxt = EMPTY ? DRAIN : RUN;
        end
      end
      RUN: begin
        cnt_nxt = cnt_r + 16'd1;
        if (d_inc < (d_width+1)'(D_LIMIT)) begin
          d_nxt = d_inc[d_width-1:0];
        end else if (z_sum[z_width] || (z_sum >= (z_width+1)'(Z_LIMIT))) begin
          state_nxt = DRAIN;
          drain_nxt = '0;
        end else begin
          d_nxt = d_width'(D_START);
          z_nxt = z_sum[z_width-1:0];
        end
      end
      DRAIN: begin
        if (drain_r == CW'(pipeline - 1)) state_nxt = DONE;
        else drain_nxt = drain_r + 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign issue = (state == RUN);
  assign div0  = issue && (d_r == '0);
  assign ovf   = issue && ovf_pred(32'(z_r[z_width-1:d_width]), 32'(d_r));

  assign line_in = {issue, z_r, d_r, div0, ovf};

  div_delay_line #(.depth(pipeline), .width(LW)) u_line (
    .clk  (clk),
    .rst_n(rst_n),
    .ena  (ena),
    .din  (line_in),
    .dout (line_out)
  );

  assign {bus.res_vld, bus.res_z, bus.res_d, bus.exp_div0, bus.exp_ovf} = line_out;

  assign bus.z         = z_r;
  assign bus.d         = d_r;
  assign bus.issue_vld = issue;
  assign bus.busy      = (state == RUN) || (state == DRAIN);
  assign bus.done      = (state == DONE);
  assign bus.vec_cnt   = cnt_r;
endmodule

// File: tb/tb_div_operand_gen.sv
// Directed bench for div_operand_gen: default sweep, ena gating, mid-sweep reset, divide-by-zero range.
module tb_div_operand_gen;
  localparam int ZW   = 16;
  localparam int DW   = 8;
  localparam int PIPE = 12;

  typedef struct {
    int z;
    int d;
    int e;
  } pair_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic ena   = 1'b1;
  logic ena2  = 1'b1;
  int testCount = 0;
  int failCount = 0;
  pair_t pq[$];

  always #5 clk = ~clk;

  div_operand_gen_if #(.z_width(ZW), .d_width(DW)) bus ();
  div_operand_gen_if #(.z_width(ZW), .d_width(DW)) bus2 ();

  div_operand_gen #(.z_width(ZW), .d_width(DW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ena  (ena),
    .bus  (bus.master)
  );

  div_operand_gen #(.z_width(ZW), .d_width(DW), .D_START(0), .D_LIMIT(2)) dut2 (
    .clk  (clk),
    .rst_n(rst_n),
    .ena  (ena2),
    .bus  (bus2.master)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Runs one default sweep from a start pulse, optionally dropping ena for gapLen cycles at gapAt
  task automatic applyStimulus(input int gapAt, input int gapLen,
                               output int kDone, output int nVec, output int firstRes);
    int ez, ed, e;
    logic [31:0] hz, hd, hrz, hcnt;
    pair_t p;
    pq.delete();
    ez = 50; ed = 10; e = 0; nVec = 0; kDone = -1; firstRes = -1;
    hz = '0; hd = '0; hrz = '0; hcnt = '0;
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      ena = !(k >= gapAt && k < gapAt + gapLen);
      if (k == gapAt) begin
        hz = 32'(bus.z); hd = 32'(bus.d); hrz = 32'(bus.res_z); hcnt = 32'(bus.vec_cnt);
      end
      if (k > gapAt && k <= gapAt + gapLen) begin
        checkOutput("hold_z", 32'(bus.z), hz);
        checkOutput("hold_d", 32'(bus.d), hd);
        checkOutput("hold_res_z", 32'(bus.res_z), hrz);
        checkOutput("hold_vec_cnt", 32'(bus.vec_cnt), hcnt);
      end
      if (bus.done) begin
        kDone = k;
        break;
      end
      if (ena) begin
        if (bus.issue_vld) begin
          checkOutput("issue_z", 32'(bus.z), 32'(ez));
          checkOutput("issue_d", 32'(bus.d), 32'(ed));
          pq.push_back('{int'(bus.z), int'(bus.d), e});
          nVec++;
          if (ed + 1 < 15) ed++;
          else begin ed = 10; ez += 123; end
        end
        if (bus.res_vld) begin
          if (firstRes < 0) firstRes = k;
          if (pq.size() == 0) checkOutput("res_spurious", 32'(bus.res_vld), 0);
          else begin
            p = pq.pop_front();
            checkOutput("res_z", 32'(bus.res_z), 32'(p.z));
            checkOutput("res_d", 32'(bus.res_d), 32'(p.d));
            checkOutput("res_latency", 32'(e - p.e), PIPE);
            checkOutput("exp_div0", 32'(bus.exp_div0), 32'(p.d == 0));
            checkOutput("exp_ovf", 32'(bus.exp_ovf), 32'(p.d != 0 && (p.z >> 8) >= p.d));
            if (p.z == 2633 && p.d == 10) checkOutput("ovf_2633_10", 32'(bus.exp_ovf), 1);
            if (p.z == 2510 && p.d == 10) checkOutput("ovf_2510_10", 32'(bus.exp_ovf), 0);
            if (p.z == 4970 && p.d == 14) checkOutput("ovf_4970_14", 32'(bus.exp_ovf), 1);
          end
        end else begin
          checkOutput("flags_idle", 32'({bus.exp_div0, bus.exp_ovf}), 0);
        end
        e++;
      end
      @(negedge clk);
    end
    ena = 1'b1;
    if (kDone < 0) checkOutput("done_timeout", 32'(bus.done), 1);
  endtask

  initial begin
    int kDone, nVec, firstRes, ez, ed, e, k2Done, n2;
    logic found;
    pair_t p;
    pair_t q2[$];
    bus.start  = 1'b0;
    bus2.start = 1'b0;

    // Reset with ena high
    repeat (2) @(negedge clk);
    checkOutput("rst_z", 32'(bus.z), 0);
    checkOutput("rst_d", 32'(bus.d), 0);
    checkOutput("rst_vec_cnt", 32'(bus.vec_cnt), 0);
    checkOutput("rst_ctrl", 32'({bus.issue_vld, bus.busy, bus.done}), 0);
    checkOutput("rst_res", 32'({bus.res_vld, bus.exp_div0, bus.exp_ovf}), 0);
    checkOutput("rst_res_z", 32'(bus.res_z), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("idle_ctrl", 32'({bus.issue_vld, bus.busy, bus.done, bus.res_vld}), 0);
    checkOutput("idle_vec_cnt", 32'(bus.vec_cnt), 0);

    // Default sweep, ena constant
    applyStimulus(100000, 0, kDone, nVec, firstRes);
    checkOutput("sweep_done_k", 32'(kDone), 217);
    checkOutput("sweep_nvec", 32'(nVec), 205);
    checkOutput("sweep_first_res", 32'(firstRes), PIPE);
    checkOutput("sweep_vec_cnt", 32'(bus.vec_cnt), 205);
    checkOutput("sweep_last_z", 32'(bus.z), 4970);
    checkOutput("sweep_last_d", 32'(bus.d), 14);
    checkOutput("sweep_done_ctrl", 32'({bus.busy, bus.res_vld, bus.issue_vld}), 0);
    checkOutput("sweep_queue_empty", 32'(pq.size()), 0);

    // Same sweep with a 7-cycle ena drop mid-run
    applyStimulus(60, 7, kDone, nVec, firstRes);
    checkOutput("gap_done_k", 32'(kDone), 224);
    checkOutput("gap_nvec", 32'(nVec), 205);
    checkOutput("gap_vec_cnt", 32'(bus.vec_cnt), 205);

    // Reset at vec_cnt==100, then restart
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (bus.vec_cnt == 16'd100) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("mid_reached_100", 32'(found), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_ctrl", 32'({bus.issue_vld, bus.busy, bus.done, bus.res_vld}), 0);
    checkOutput("mid_rst_vec_cnt", 32'(bus.vec_cnt), 0);
    checkOutput("mid_rst_z", 32'(bus.z), 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    checkOutput("restart_z", 32'(bus.z), 50);
    checkOutput("restart_d", 32'(bus.d), 10);
    checkOutput("restart_issue", 32'(bus.issue_vld), 1);
    checkOutput("restart_vec_cnt", 32'(bus.vec_cnt), 0);
    repeat (5) @(negedge clk);
    checkOutput("restart_no_flush", 32'(bus.res_vld), 0);

    // Divide-by-zero range on the second instance, with a stray start during RUN
    ez = 50; ed = 0; e = 0; n2 = 0; k2Done = -1;
    @(negedge clk); bus2.start = 1'b1;
    @(negedge clk); bus2.start = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      bus2.start = (k == 3);
      if (bus2.done) begin
        k2Done = k;
        break;
      end
      if (bus2.issue_vld) begin
        checkOutput("z2_issue_z", 32'(bus2.z), 32'(ez));
        checkOutput("z2_issue_d", 32'(bus2.d), 32'(ed));
        q2.push_back('{int'(bus2.z), int'(bus2.d), e});
        n2++;
        if (ed + 1 < 2) ed++;
        else begin ed = 0; ez += 123; end
      end
      if (bus2.res_vld) begin
        if (q2.size() == 0) checkOutput("z2_res_spurious", 32'(bus2.res_vld), 0);
        else begin
          p = q2.pop_front();
          checkOutput("z2_res_z", 32'(bus2.res_z), 32'(p.z));
          checkOutput("z2_res_d", 32'(bus2.res_d), 32'(p.d));
          checkOutput("z2_latency", 32'(e - p.e), PIPE);
          if (p.d == 0) begin
            checkOutput("z2_div0", 32'(bus2.exp_div0), 1);
            checkOutput("z2_ovf_d0", 32'(bus2.exp_ovf), 0);
          end else begin
            checkOutput("z2_div0_d1", 32'(bus2.exp_div0), 0);
            checkOutput("z2_ovf_d1", 32'(bus2.exp_ovf), 32'((p.z >> 8) >= 1));
          end
        end
      end
      e++;
      @(negedge clk);
    end
    bus2.start = 1'b0;
    if (k2Done < 0) checkOutput("z2_done_timeout", 32'(bus2.done), 1);
    checkOutput("z2_done_k", 32'(k2Done), 94);
    checkOutput("z2_nvec", 32'(n2), 82);
    checkOutput("z2_vec_cnt", 32'(bus2.vec_cnt), 82);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end
endmodule
